// File: rtl/pc_unit_if.sv
// Fetch-stage control/status bundle for pc_unit: the master side drives the
// control inputs and observes the fetch address and status.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) ();
    logic              stall;
    logic              halt;
    logic              resume;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              trap;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] pc_next;
    logic              fetch_valid;
    logic              halted;
    logic              misalign_err;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              ras_empty;

    modport master (
        output stall, halt, resume, redirect_valid, redirect_addr, trap,
               ras_push, ras_pop,
        input  pc_out, pc_next, fetch_valid, halted, misalign_err,
               fetch_cnt, ras_empty
    );

    modport slave (
        input  stall, halt, resume, redirect_valid, redirect_addr, trap,
               ras_push, ras_pop,
        output pc_out, pc_next, fetch_valid, halted, misalign_err,
               fetch_cnt, ras_empty
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: BOOT/RUN/HALT control, prioritised
// redirects, trap vector, saturating fetch counter. PC_UNIT_RAS_EN adds a return-address stack.
module pc_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0080),
    parameter int unsigned       INC       = 4,
    parameter int unsigned       CNT_W     = 16,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              r_mis;
    logic              w_mis_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_fetch_valid;
    logic              w_stall_win;
    logic              w_pop_ok;
    logic              w_push;
    logic              w_pop;
    logic              w_ras_empty;
    logic [ADDR_W-1:0] w_ras_top;

    assign w_pc_inc = r_pc + ADDR_W'(INC);
    assign w_pop_ok = bus.ras_pop & ~w_ras_empty;

`ifdef PC_UNIT_RAS_EN
    localparam int unsigned       PTR_W      = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]    DEPTH_FULL = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [PTR_W:0]    r_depth;

    assign w_ras_empty = (r_depth == '0);
    assign w_ras_top   = r_ras[r_top];

    // Circular buffer: a push onto a full stack lands on the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_top   <= '0;
            r_depth <= '0;
        end else if (w_push && !w_pop) begin
            r_top <= r_top + 1'b1;
            if (r_depth != DEPTH_FULL) begin
                r_depth <= r_depth + 1'b1;
            end
        end else if (w_pop && !w_push) begin
            r_top   <= r_top - 1'b1;
            r_depth <= r_depth - 1'b1;
        end
    end

    // Push with pop replaces the old top in place, so depth is unchanged.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            if (w_pop) begin
                r_ras[r_top] <= w_pc_inc;
            end else begin
                r_ras[r_top + 1'b1] <= w_pc_inc;
            end
        end
    end
`else
    logic w_unused_ras;

    assign w_ras_empty  = 1'b1;
    assign w_ras_top    = '0;
    assign w_unused_ras = &{1'b0, w_push, w_pop, (RAS_DEPTH != 0)};
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_mis_nxt     = r_mis;
        w_stall_win   = 1'b0;
        w_fetch_valid = 1'b0;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            BOOT: begin
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = RUN;
            end
            RUN: begin
                w_stall_win   = bus.stall & ~bus.trap & ~bus.redirect_valid & ~w_pop_ok;
                w_fetch_valid = ~w_stall_win;
                if (bus.trap) begin
                    w_pc_nxt = TRAP_VEC;
                end else if (bus.halt) begin
                    w_state_nxt = HALT;
                end else if (bus.redirect_valid) begin
                    w_pc_nxt = {bus.redirect_addr[ADDR_W-1:2], 2'b00};
                    if (bus.redirect_addr[1:0] != 2'b00) begin
                        w_mis_nxt = 1'b1;
                    end
                end else if (w_pop_ok) begin
                    w_pc_nxt = w_ras_top;
                    w_pop    = 1'b1;
                    w_push   = bus.ras_push;
                end else if (!bus.stall) begin
                    w_pc_nxt = w_pc_inc;
                    w_push   = bus.ras_push;
                end
            end
            HALT: begin
                if (bus.trap) begin
                    w_pc_nxt    = TRAP_VEC;
                    w_state_nxt = RUN;
                end else if (bus.resume) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_VEC;
            r_mis   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_mis   <= w_mis_nxt;
            if (w_fetch_valid && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_out       = r_pc;
    assign bus.pc_next      = w_pc_inc;
    assign bus.fetch_valid  = w_fetch_valid;
    assign bus.halted       = (r_state == HALT);
    assign bus.misalign_err = r_mis;
    assign bus.fetch_cnt    = r_cnt;
    assign bus.ras_empty    = w_ras_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 32-bit and an 8-bit/3-bit-counter instance share one
// directed stimulus; a queue-based model is checked every cycle plus literal pins.
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int MD_BOOT = 0;
    localparam int MD_RUN  = 1;
    localparam int MD_HALT = 2;

    logic        clk = 1'b0;
    logic        s_rst, s_stall, s_halt, s_resume, s_redir, s_trap, s_push, s_pop;
    logic [31:0] s_addr;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    pc_unit_if #(.ADDR_W(32), .CNT_W(16)) ifa ();
    pc_unit_if #(.ADDR_W(8),  .CNT_W(3))  ifb ();

    pc_unit #(
        .ADDR_W(32), .RESET_VEC(32'h0000_0100), .TRAP_VEC(32'h0000_0080),
        .INC(4), .CNT_W(16), .RAS_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(s_rst), .bus(ifa)
    );

    pc_unit #(
        .ADDR_W(8), .RESET_VEC(8'hF4), .TRAP_VEC(8'h80),
        .INC(4), .CNT_W(3), .RAS_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(s_rst), .bus(ifb)
    );

    assign ifa.stall = s_stall;          assign ifb.stall = s_stall;
    assign ifa.halt = s_halt;            assign ifb.halt = s_halt;
    assign ifa.resume = s_resume;        assign ifb.resume = s_resume;
    assign ifa.redirect_valid = s_redir; assign ifb.redirect_valid = s_redir;
    assign ifa.redirect_addr = s_addr;   assign ifb.redirect_addr = s_addr[7:0];
    assign ifa.trap = s_trap;            assign ifb.trap = s_trap;
    assign ifa.ras_push = s_push;        assign ifb.ras_push = s_push;
    assign ifa.ras_pop = s_pop;          assign ifb.ras_pop = s_pop;

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_mode [2];
    logic [31:0] m_pc   [2];
    bit          m_mis  [2];
    int unsigned m_cnt  [2];
    bit          m_known[2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    function automatic logic [31:0] msk(input int i);
        return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic int unsigned cmax(input int i);
        return (i == 0) ? 65535 : 7;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int i, input logic [31:0] v);
        if (i == 0) begin
            q0.push_back(v);
            if (q0.size() > 4) void'(q0.pop_front());
        end else begin
            q1.push_back(v);
            if (q1.size() > 4) void'(q1.pop_front());
        end
    endtask

    task automatic qpop(input int i, output logic [31:0] v);
        if (i == 0) v = q0.pop_back();
        else        v = q1.pop_back();
    endtask

    function automatic bit exp_fv(input int i);
        bit pop_ok;
        pop_ok = RAS_EN && s_pop && (qsize(i) > 0);
        return (m_mode[i] == MD_RUN) && !(s_stall && !s_trap && !s_redir && !pop_ok);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        logic [31:0] m;
        logic [31:0] nxt;
        logic [31:0] top;
        bit          pop_ok;
        m   = msk(i);
        nxt = (m_pc[i] + 32'd4) & m;
        if (s_rst) begin
            m_pc[i]    = (i == 0) ? 32'h100 : 32'hF4;
            m_mode[i]  = MD_BOOT;
            m_mis[i]   = 1'b0;
            m_cnt[i]   = 0;
            m_known[i] = 1'b1;
            if (i == 0) q0.delete(); else q1.delete();
            return;
        end
        if (!m_known[i]) return;
        if (exp_fv(i) && m_cnt[i] < cmax(i)) m_cnt[i]++;
        pop_ok = RAS_EN && s_pop && (qsize(i) > 0);
        case (m_mode[i])
            MD_BOOT: begin
                m_pc[i]   = nxt;
                m_mode[i] = MD_RUN;
            end
            MD_HALT: begin
                if (s_trap) begin
                    m_pc[i]   = 32'h80;
                    m_mode[i] = MD_RUN;
                end else if (s_resume) begin
                    m_mode[i] = MD_RUN;
                end
            end
            default: begin
                if (s_trap) begin
                    m_pc[i] = 32'h80;
                end else if (s_halt) begin
                    m_mode[i] = MD_HALT;
                end else if (s_redir) begin
                    m_pc[i] = s_addr & m & ~32'h3;
                    if (s_addr[1:0] != 2'b00) m_mis[i] = 1'b1;
                end else if (pop_ok) begin
                    qpop(i, top);
                    m_pc[i] = top;
                    if (s_push) qpush(i, nxt);
                end else if (!s_stall) begin
                    m_pc[i] = nxt;
                    if (RAS_EN && s_push) qpush(i, nxt);
                end
            end
        endcase
    endtask

    task automatic compare_inst(input int i);
        string p;
        p = (i == 0) ? "A" : "B";
        if (i == 0) begin
            chk({p, " pc_out"}, ifa.pc_out, m_pc[0]);
            chk({p, " pc_next"}, ifa.pc_next, m_pc[0] + 32'd4);
            chk({p, " fetch_valid"}, 32'(ifa.fetch_valid), 32'(exp_fv(0)));
            chk({p, " halted"}, 32'(ifa.halted), 32'(m_mode[0] == MD_HALT));
            chk({p, " misalign_err"}, 32'(ifa.misalign_err), 32'(m_mis[0]));
            chk({p, " fetch_cnt"}, 32'(ifa.fetch_cnt), m_cnt[0]);
            chk({p, " ras_empty"}, 32'(ifa.ras_empty), 32'(qsize(0) == 0));
        end else begin
            chk({p, " pc_out"}, 32'(ifb.pc_out), m_pc[1]);
            chk({p, " pc_next"}, 32'(ifb.pc_next), (m_pc[1] + 32'd4) & 32'hFF);
            chk({p, " fetch_valid"}, 32'(ifb.fetch_valid), 32'(exp_fv(1)));
            chk({p, " halted"}, 32'(ifb.halted), 32'(m_mode[1] == MD_HALT));
            chk({p, " misalign_err"}, 32'(ifb.misalign_err), 32'(m_mis[1]));
            chk({p, " fetch_cnt"}, 32'(ifb.fetch_cnt), m_cnt[1]);
            chk({p, " ras_empty"}, 32'(ifb.ras_empty), 32'(qsize(1) == 0));
        end
    endtask

    // Compare on the falling edge, then advance the model with the inputs
    // that the next rising edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m_known[i]) compare_inst(i);
            end
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        s_rst = 1'b1; s_stall = 1'b0; s_halt = 1'b0; s_resume = 1'b0;
        s_redir = 1'b0; s_trap = 1'b0; s_push = 1'b0; s_pop = 1'b0;
        s_addr = '0;

        // reset and boot
        tick(2); s_rst = 1'b0; #1;
        chk("lit boot pc", ifa.pc_out, 32'h100);
        chk("lit boot fv", 32'(ifa.fetch_valid), 32'd0);
        chk("lit boot halted", 32'(ifa.halted), 32'd0);
        chk("lit boot mis", 32'(ifa.misalign_err), 32'd0);
        chk("lit boot cnt", 32'(ifa.fetch_cnt), 32'd0);
        chk("lit boot ras_empty", 32'(ifa.ras_empty), 32'd1);
        chk("lit B boot pc", 32'(ifb.pc_out), 32'hF4);
        tick(1); #1;
        chk("lit run pc0", ifa.pc_out, 32'h104);
        chk("lit run fv", 32'(ifa.fetch_valid), 32'd1);
        tick(1); #1;
        chk("lit run pc1", ifa.pc_out, 32'h108);
        chk("lit run cnt", 32'(ifa.fetch_cnt), 32'd1);
        chk("lit B pc FC", 32'(ifb.pc_out), 32'hFC);
        chk("lit B pc_next wrap", 32'(ifb.pc_next), 32'h00);

        // stall + misaligned redirect: redirect wins
        tick(1); s_stall = 1'b1; s_redir = 1'b1; s_addr = 32'h2003; #1;
        chk("lit pc 10C", ifa.pc_out, 32'h10C);
        chk("lit redir fv", 32'(ifa.fetch_valid), 32'd1);
        chk("lit B wrapped pc", 32'(ifb.pc_out), 32'h00);
        tick(1); s_redir = 1'b0; #1;
        chk("lit redir pc", ifa.pc_out, 32'h2000);
        chk("lit misalign", 32'(ifa.misalign_err), 32'd1);
        chk("lit stall fv", 32'(ifa.fetch_valid), 32'd0);
        chk("lit cnt before stall", 32'(ifa.fetch_cnt), 32'd3);
        tick(3); #1;
        chk("lit stall pc", ifa.pc_out, 32'h2000);
        chk("lit stall cnt", 32'(ifa.fetch_cnt), 32'd3);

        // halt / resume / trap
        s_stall = 1'b0; s_redir = 1'b1; s_addr = 32'h40;
        tick(1); s_redir = 1'b0; s_halt = 1'b1; #1;
        chk("lit pc 40", ifa.pc_out, 32'h40);
        tick(1); s_halt = 1'b0; #1;
        chk("lit halted", 32'(ifa.halted), 32'd1);
        chk("lit halt pc", ifa.pc_out, 32'h40);
        chk("lit halt fv", 32'(ifa.fetch_valid), 32'd0);
        tick(2); s_resume = 1'b1; #1;
        chk("lit halt hold pc", ifa.pc_out, 32'h40);
        tick(1); s_resume = 1'b0; #1;
        chk("lit resume halted", 32'(ifa.halted), 32'd0);
        chk("lit resume pc", ifa.pc_out, 32'h40);
        tick(1); s_halt = 1'b1; #1;
        chk("lit resume pc+4", ifa.pc_out, 32'h44);
        tick(1); s_halt = 1'b0; s_trap = 1'b1; #1;
        chk("lit halted 2", 32'(ifa.halted), 32'd1);
        tick(1); s_halt = 1'b1; #1;
        chk("lit trap pc", ifa.pc_out, 32'h80);
        chk("lit trap halted", 32'(ifa.halted), 32'd0);
        tick(1); s_halt = 1'b0; s_trap = 1'b0; #1;
        chk("lit trap+halt pc", ifa.pc_out, 32'h80);
        chk("lit trap+halt halted", 32'(ifa.halted), 32'd0);
        tick(1); #1;
        chk("lit cnt 9", 32'(ifa.fetch_cnt), 32'd9);
        chk("lit B cnt sat", 32'(ifb.fetch_cnt), 32'd7);

        // return-address stack
        for (int i = 1; i <= 5; i++) begin
            s_redir = 1'b1; s_addr = 32'(i * 16);
            tick(1); s_redir = 1'b0; s_push = 1'b1; #1;
            chk("lit push site", ifa.pc_out, 32'(i * 16));
            tick(1); s_push = 1'b0; #1;
            chk("lit after push", ifa.pc_out, 32'(i * 16 + 4));
        end
`ifdef PC_UNIT_RAS_EN
        chk("lit ras nonempty", 32'(ifa.ras_empty), 32'd0);
        s_pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1); #1;
            chk("lit pop pc", ifa.pc_out, 32'h54 - 32'(16 * k));
        end
        tick(1); #1;
        chk("lit empty pop pc", ifa.pc_out, 32'h28);
        chk("lit empty after pops", 32'(ifa.ras_empty), 32'd1);
        s_pop = 1'b0; s_push = 1'b1;
        tick(1); #1;
        chk("lit push 2C", ifa.pc_out, 32'h2C);
        s_pop = 1'b1;
        tick(1); s_push = 1'b0; #1;
        chk("lit push+pop pc", ifa.pc_out, 32'h2C);
        tick(1); s_pop = 1'b0; #1;
        chk("lit pop replaced", ifa.pc_out, 32'h30);
        chk("lit depth kept", 32'(ifa.ras_empty), 32'd1);
`else
        chk("lit ras tied empty", 32'(ifa.ras_empty), 32'd1);
        s_pop = 1'b1;
        tick(1); s_pop = 1'b0; #1;
        chk("lit pop ignored", ifa.pc_out, 32'h58);
`endif

        // reset while halted with the stack in use
        s_push = 1'b1;
        tick(1); s_push = 1'b0; s_halt = 1'b1;
        tick(1); s_halt = 1'b0; #1;
        chk("lit pre-rst halted", 32'(ifa.halted), 32'd1);
`ifdef PC_UNIT_RAS_EN
        chk("lit pre-rst ras", 32'(ifa.ras_empty), 32'd0);
`endif
        s_rst = 1'b1;
        tick(1); s_rst = 1'b0; #1;
        chk("lit rst pc", ifa.pc_out, 32'h100);
        chk("lit rst halted", 32'(ifa.halted), 32'd0);
        chk("lit rst mis", 32'(ifa.misalign_err), 32'd0);
        chk("lit rst cnt", 32'(ifa.fetch_cnt), 32'd0);
        chk("lit rst ras_empty", 32'(ifa.ras_empty), 32'd1);
        chk("lit rst fv", 32'(ifa.fetch_valid), 32'd0);
        tick(3); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the plain PC register.
- Sits at the head of the MIPS fetch stage, drives the instruction-memory address each cycle.
- Adds reset vector, sequential increment, stall, branch/jump redirect, trap vector, halt state and a saturating fetch counter.
- An optional return-address stack handles call/return.

Parameters:
- ADDR_W, 32, PC width in bits (minimum 8).
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0080, PC value loaded on trap.
- INC, 4, byte increment per sequential fetch.
- CNT_W, 16, width of the fetch counter.
- RAS_DEPTH, 4, return-address-stack entries (power of two, 2..16); used only with the optional feature.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset: synchronous, active-high.
- stall, input, 1, hold the current PC.
- halt, input, 1, request to enter HALT.
- resume, input, 1, leave HALT.
- redirect_valid, input, 1, take redirect_addr (branch or jump).
- redirect_addr, input, ADDR_W, redirect target.
- trap, input, 1, jump to TRAP_VEC.
- ras_push, input, 1, call: push pc_out+INC.
- ras_pop, input, 1, return: redirect to the top of the stack.
- pc_out, output, ADDR_W, current fetch address.
- pc_next, output, ADDR_W, combinational pc_out+INC (wraps modulo 2^ADDR_W).
- fetch_valid, output, 1, pc_out is a valid fetch address this cycle.
- halted, output, 1, the FSM is in HALT.
- misalign_err, output, 1, sticky flag: a misaligned redirect was seen.
- fetch_cnt, output, CNT_W, number of valid fetches, saturating.
- ras_empty, output, 1, the stack is empty.

Behaviour:
- One clock; reset is synchronous and active-high.
- Outputs on the cycle after rst is sampled high:
  - pc_out=RESET_VEC, fetch_valid=0, halted=0, misalign_err=0, fetch_cnt=0, ras_empty=1.
  - FSM state is BOOT.
- FSM states: BOOT, RUN, HALT.
  - BOOT -> RUN unconditionally after one cycle; fetch_valid=0 in BOOT.
  - RUN -> HALT when halt=1 and trap=0. pc_out freezes at its current value and fetch_valid becomes 0 on the next cycle.
  - HALT -> RUN when resume=1. pc_out is unchanged on exit; the fetch resumes at the frozen PC.
  - HALT -> RUN on trap=1, which also loads TRAP_VEC.
  - All other inputs except rst are ignored in HALT.
- PC update in RUN, strict priority high to low:
  1. rst
  2. trap -> TRAP_VEC
  3. redirect_valid -> {redirect_addr[ADDR_W-1:2], 2'b00}
  4. ras_pop (only when the stack is non-empty) -> top entry
  5. stall -> hold
  6. otherwise -> pc_out+INC
- Latency: each selected source appears on pc_out exactly one cycle after it is sampled.
- Misaligned redirect: redirect_valid=1 with redirect_addr[1:0]!=0 sets misalign_err the next cycle. The flag stays set until rst. The target is still taken, with its low two bits cleared.
- Wrap-around: pc_out+INC wraps modulo 2^ADDR_W with no flag.
- fetch_valid=1 in RUN except while stall=1 is the winning action. It stays 1 on a redirect or trap cycle.
- fetch_cnt increments on every cycle with fetch_valid=1 and saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events:
  - trap with halt: trap wins and the FSM stays in RUN.
  - redirect with stall: redirect wins.
  - rst dominates everything, including mid-HALT and mid-redirect.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- Defined:
  - A RAS_DEPTH-entry circular stack.
  - ras_push in RUN, when not stalled and not overridden by trap, writes pc_out+INC.
  - Push while full overwrites the oldest entry; the stack stays full.
  - ras_pop while empty is ignored (no redirect, no underflow).
  - Push and pop in the same cycle: the pop redirect is taken from the old top, then the new value is pushed; the stack depth is unchanged.
  - Push and pop are ignored on any cycle where trap or redirect_valid wins.
  - rst empties the stack.
- Undefined:
  - No stack storage is built.
  - ras_push and ras_pop are ignored.
  - ras_empty is tied to 1.

Test Plan:
- Reset/boot: RESET_VEC=32'h100, rst high for 2 cycles then low -> pc_out=32'h100 and fetch_valid=0 for one cycle, then pc_out=32'h104 with fetch_valid=1, then 32'h108.
- Stall/redirect priority: at pc_out=32'h10C, assert stall and redirect_valid with redirect_addr=32'h2003 -> next pc_out=32'h2000 and misalign_err=1. Then stall alone for 3 cycles -> pc_out holds 32'h2000, fetch_valid=0, fetch_cnt frozen.
- Halt/trap: halt at pc_out=32'h40 -> halted=1 and pc_out=32'h40 held. Resume -> pc_out=32'h40 then 32'h44. A second halt followed by trap -> pc_out=32'h80 and halted=0.
- Wrap and saturate: ADDR_W=8, CNT_W=3, pc_out=8'hFC -> next pc_out=8'h00. After 7 valid fetches, fetch_cnt stays at 7.
- RAS (PC_UNIT_RAS_EN, RAS_DEPTH=4):
  - Push at pc_out=32'h10, 32'h20, 32'h30, 32'h40, 32'h50 (overflow overwrites the 32'h14 entry).
  - Four pops -> pc_out=32'h54, 32'h44, 32'h34, 32'h24.
  - A fifth pop is ignored, pc_out increments normally, and ras_empty=1.
- Reset mid-operation: rst asserted during HALT with the stack non-empty -> pc_out=RESET_VEC, halted=0, misalign_err=0, fetch_cnt=0, ras_empty=1.
